// File: rtl/cheshire_reg_arbiter.sv
// Round-robin arbiter sharing one cheshire reg_ext port among NumReq masters, one transaction in flight.
// Optional BUSY watchdog abort enabled by defining CHESHIRE_REG_ARB_TIMEOUT_EN.
module cheshire_reg_arbiter #(
  parameter int unsigned NumReq        = 4,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReq-1:0]             slv_valid_i,
  input  logic [NumReq-1:0]             slv_write_i,
  input  logic [NumReq*AddrWidth-1:0]   slv_addr_i,
  input  logic [NumReq*DataWidth-1:0]   slv_wdata_i,
  input  logic [NumReq*DataWidth/8-1:0] slv_wstrb_i,
  output logic [NumReq-1:0]             slv_ready_o,
  output logic [DataWidth-1:0]          slv_rdata_o,
  output logic                          slv_error_o,
  output logic                          mst_valid_o,
  output logic                          mst_write_o,
  output logic [AddrWidth-1:0]          mst_addr_o,
  output logic [DataWidth-1:0]          mst_wdata_o,
  output logic [DataWidth/8-1:0]        mst_wstrb_o,
  input  logic                          mst_ready_i,
  input  logic [DataWidth-1:0]          mst_rdata_i,
  input  logic                          mst_error_i,
  output logic                          busy_o,
  output logic [$clog2(NumReq)-1:0]     gnt_idx_o
);

  localparam int unsigned IdxW  = $clog2(NumReq);
  localparam int unsigned StrbW = DataWidth / 8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [IdxW-1:0] rr_q, rr_d;
  logic [IdxW-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0] pick, cand;
  logic            found;
  logic            active;
  logic            abort;

  // Outputs are forced low during reset so an abandoned transaction never pulses ready.
  assign active = rst_ni && (state_q == BUSY);

  always_comb begin
    pick  = rr_q;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NumReq; k++) begin
      cand = IdxW'((32'(rr_q) + 32'(k)) % NumReq);
      if (!found && slv_valid_i[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

`ifdef CHESHIRE_REG_ARB_TIMEOUT_EN
  logic [31:0] cnt_q;

  // A ready in the same cycle as the limit wins over the abort.
  assign abort = (state_q == BUSY) && !mst_ready_i && (cnt_q == 32'(TimeoutCycles - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
    end else if (!mst_ready_i) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end
`else
  assign abort = 1'b0 & (TimeoutCycles == 0);
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    gnt_d       = gnt_q;
    mst_valid_o = 1'b0;
    mst_write_o = 1'b0;
    mst_addr_o  = '0;
    mst_wdata_o = '0;
    mst_wstrb_o = '0;
    slv_ready_o = '0;
    slv_rdata_o = '0;
    slv_error_o = 1'b0;
    busy_o      = active;
    gnt_idx_o   = '0;
    unique case (state_q)
      IDLE: begin
        if (|slv_valid_i) begin
          gnt_d   = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (active) begin
          mst_valid_o = 1'b1;
          mst_write_o = slv_write_i[gnt_q];
          mst_addr_o  = slv_addr_i[gnt_q*AddrWidth +: AddrWidth];
          mst_wdata_o = slv_wdata_i[gnt_q*DataWidth +: DataWidth];
          mst_wstrb_o = slv_wstrb_i[gnt_q*StrbW +: StrbW];
          gnt_idx_o   = gnt_q;
          if (mst_ready_i || abort) begin
            slv_ready_o = NumReq'(1) << gnt_q;
            slv_rdata_o = mst_ready_i ? mst_rdata_i : '0;
            slv_error_o = mst_ready_i ? mst_error_i : 1'b1;
          end
        end
        if (mst_ready_i || abort) begin
          state_d = IDLE;
          rr_d    = (gnt_q == IdxW'(NumReq - 1)) ? '0 : gnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Granted requester must hold valid until its completion.
  a_hold_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == BUSY) |-> slv_valid_i[gnt_q]);

endmodule

// File: tb/tb_cheshire_reg_arbiter.sv
// Self-checking bench for cheshire_reg_arbiter: per-cycle transaction-level model plus directed literal checks.
// Timeout behaviour follows CHESHIRE_REG_ARB_TIMEOUT_EN as seen by the bench build.
module tb_cheshire_reg_arbiter;

  localparam int N      = 4;
  localparam int TO_CYC = 8;
`ifdef CHESHIRE_REG_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   slv_valid, slv_write;
  logic [127:0] slv_addr, slv_wdata;
  logic [15:0]  slv_wstrb;
  logic [3:0]   slv_ready;
  logic [31:0]  slv_rdata;
  logic         slv_error;
  logic         mst_valid, mst_write;
  logic [31:0]  mst_addr, mst_wdata;
  logic [3:0]   mst_wstrb;
  logic         mst_ready;
  logic [31:0]  mst_rdata;
  logic         mst_error;
  logic         busy;
  logic [1:0]   gnt_idx;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit chk_en    = 1'b0;

  // Transaction-level model: who owns the bus, whose turn is next, how long it has waited.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_next  = 0;
  int m_cnt   = 0;

  always #5 clk = ~clk;

  cheshire_reg_arbiter #(
    .NumReq(N), .AddrWidth(32), .DataWidth(32), .TimeoutCycles(TO_CYC)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_valid_i(slv_valid), .slv_write_i(slv_write), .slv_addr_i(slv_addr),
    .slv_wdata_i(slv_wdata), .slv_wstrb_i(slv_wstrb),
    .slv_ready_o(slv_ready), .slv_rdata_o(slv_rdata), .slv_error_o(slv_error),
    .mst_valid_o(mst_valid), .mst_write_o(mst_write), .mst_addr_o(mst_addr),
    .mst_wdata_o(mst_wdata), .mst_wstrb_o(mst_wstrb),
    .mst_ready_i(mst_ready), .mst_rdata_i(mst_rdata), .mst_error_i(mst_error),
    .busy_o(busy), .gnt_idx_o(gnt_idx)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int rr_pick(input int start, input logic [3:0] v);
    for (int k = 0; k < N; k++)
      if (v[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  function automatic bit m_timeout();
    return TO_EN && !mst_ready && (m_cnt == TO_CYC - 1);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_next <= 0;
      m_cnt  <= 0;
    end else if (!m_busy) begin
      if (slv_valid != 4'b0) begin
        m_owner <= rr_pick(m_next, slv_valid);
        m_busy  <= 1'b1;
        m_cnt   <= 0;
      end
    end else if (mst_ready || m_timeout()) begin
      m_busy <= 1'b0;
      m_next <= (m_owner + 1) % N;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit          eb, ed;
      logic [3:0]  er;
      logic [31:0] ea, ew, ed32;
      logic [3:0]  es;
      eb   = rst_n && m_busy;
      ed   = eb && (mst_ready || m_timeout());
      er   = ed ? (4'b0001 << m_owner) : 4'b0000;
      ea   = eb ? slv_addr[m_owner*32 +: 32] : 32'h0;
      ew   = eb ? slv_wdata[m_owner*32 +: 32] : 32'h0;
      es   = eb ? slv_wstrb[m_owner*4 +: 4] : 4'h0;
      ed32 = (eb && mst_ready) ? mst_rdata : 32'h0;
      check("model_busy", {63'h0, busy}, {63'h0, eb});
      check("model_mst_valid", {63'h0, mst_valid}, {63'h0, eb});
      check("model_mst_write", {63'h0, mst_write}, {63'h0, eb && slv_write[m_owner]});
      check("model_mst_addr", {32'h0, mst_addr}, {32'h0, ea});
      check("model_mst_wdata", {32'h0, mst_wdata}, {32'h0, ew});
      check("model_mst_wstrb", {60'h0, mst_wstrb}, {60'h0, es});
      check("model_gnt_idx", {62'h0, gnt_idx}, eb ? 64'(m_owner) : 64'h0);
      check("model_slv_ready", {60'h0, slv_ready}, {60'h0, er});
      check("model_slv_rdata", {32'h0, slv_rdata}, {32'h0, ed32});
      check("model_slv_error", {63'h0, slv_error},
            {63'h0, ed && (mst_ready ? mst_error : 1'b1)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    slv_valid[i]       = 1'b1;
    slv_write[i]       = w;
    slv_addr[i*32 +: 32]  = a;
    slv_wdata[i*32 +: 32] = d;
    slv_wstrb[i*4 +: 4]   = s;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    rst_n = 1'b0; slv_valid = '0; slv_write = '0; slv_addr = '0; slv_wdata = '0; slv_wstrb = '0;
    mst_ready = 1'b0; mst_rdata = '0; mst_error = 1'b0;
    repeat (2) tick();
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_busy", {63'h0, busy}, 64'h0);
    check("reset_gnt", {62'h0, gnt_idx}, 64'h0);
    tick();
    rst_n = 1'b1;

    // ready while idle is ignored
    mst_ready = 1'b1; mst_rdata = 32'h1111_1111;
    tick();
    mst_ready = 1'b0;

    // read from req1 with a slow downstream
    set_req(1, 1'b0, 32'h0300_0010, 32'h0, 4'h0);
    tick();
    @(negedge clk);
    check("read_gnt", {62'h0, gnt_idx}, 64'd1);
    check("read_addr", {32'h0, mst_addr}, 64'h0300_0010);
    repeat (3) tick();
    mst_ready = 1'b1; mst_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("read_ready", {60'h0, slv_ready}, 64'b0010);
    check("read_rdata", {32'h0, slv_rdata}, 64'hDEAD_BEEF);
    check("read_error", {63'h0, slv_error}, 64'h0);
    tick();
    slv_valid = '0; mst_ready = 1'b0;
    @(negedge clk);
    check("read_idle", {63'h0, busy}, 64'h0);

    // contention after reset
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    set_req(0, 1'b0, 32'h0300_0004, 32'h0, 4'h0);
    set_req(2, 1'b0, 32'h0300_0008, 32'h0, 4'h0);
    mst_ready = 1'b1; mst_rdata = 32'h0000_00A5;
    tick();
    @(negedge clk);
    check("cont_gnt0", {62'h0, gnt_idx}, 64'd0);
    check("cont_ready0", {60'h0, slv_ready}, 64'b0001);
    tick();
    slv_valid[0] = 1'b0;
    @(negedge clk);
    check("cont_gap", {63'h0, busy}, 64'h0);
    tick();
    @(negedge clk);
    check("cont_gnt2", {62'h0, gnt_idx}, 64'd2);
    check("cont_ready2", {60'h0, slv_ready}, 64'b0100);
    tick();
    slv_valid = '0; mst_ready = 1'b0;

    // fairness and pointer wrap
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'h0300_0100 + 32'(i * 4), 32'h0, 4'h0);
    mst_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      @(negedge clk);
      check("rr_gnt", {62'h0, gnt_idx}, 64'(k % N));
      check("rr_ready", {60'h0, slv_ready}, 64'(4'b0001 << (k % N)));
      tick();
    end
    slv_valid = '0; mst_ready = 1'b0;

    // write from req3 with downstream error
    set_req(3, 1'b1, 32'h0300_0000, 32'h1234_5678, 4'b0011);
    tick();
    @(negedge clk);
    check("wr_gnt", {62'h0, gnt_idx}, 64'd3);
    check("wr_write", {63'h0, mst_write}, 64'h1);
    check("wr_addr", {32'h0, mst_addr}, 64'h0300_0000);
    check("wr_wdata", {32'h0, mst_wdata}, 64'h1234_5678);
    check("wr_wstrb", {60'h0, mst_wstrb}, 64'b0011);
    tick();
    mst_ready = 1'b1; mst_error = 1'b1;
    @(negedge clk);
    check("wr_ready", {60'h0, slv_ready}, 64'b1000);
    check("wr_error", {63'h0, slv_error}, 64'h1);
    tick();
    slv_valid = '0; mst_ready = 1'b0; mst_error = 1'b0;

    // stalled downstream
    mst_rdata = 32'hFFFF_FFFF;
    set_req(0, 1'b0, 32'h0300_0020, 32'h0, 4'h0);
    tick();
`ifdef CHESHIRE_REG_ARB_TIMEOUT_EN
    for (int c = 1; c <= TO_CYC; c++) begin
      @(negedge clk);
      if (c < TO_CYC) begin
        check("to_wait", {60'h0, slv_ready}, 64'h0);
      end else begin
        check("to_ready", {60'h0, slv_ready}, 64'b0001);
        check("to_error", {63'h0, slv_error}, 64'h1);
        check("to_rdata", {32'h0, slv_rdata}, 64'h0);
      end
      tick();
    end
    slv_valid = '0;
    @(negedge clk);
    check("to_idle", {63'h0, busy}, 64'h0);
    check("to_mst_valid", {63'h0, mst_valid}, 64'h0);
`else
    repeat (100) tick();
    @(negedge clk);
    check("stall_busy", {63'h0, busy}, 64'h1);
    mst_ready = 1'b1;
    tick();
    slv_valid = '0; mst_ready = 1'b0;
`endif

    // reset in the middle of a req2 transaction, with the pointer parked at 2
    set_req(1, 1'b0, 32'h0300_0030, 32'h0, 4'h0);
    mst_ready = 1'b1;
    tick(); tick();
    slv_valid = '0; mst_ready = 1'b0;
    set_req(2, 1'b0, 32'h0300_0040, 32'h0, 4'h0);
    tick();
    @(negedge clk);
    check("rst_pre_gnt", {62'h0, gnt_idx}, 64'd2);
    tick();
    rst_n = 1'b0;
    mst_ready = 1'b1;
    set_req(1, 1'b0, 32'h0300_0030, 32'h0, 4'h0);
    @(negedge clk);
    check("rst_no_pulse", {60'h0, slv_ready}, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    tick();
    rst_n = 1'b1; mst_ready = 1'b0;
    tick();
    @(negedge clk);
    check("rst_post_gnt", {62'h0, gnt_idx}, 64'd1);
    mst_ready = 1'b1;
    tick();
    slv_valid[1] = 1'b0;
    tick();
    @(negedge clk);
    check("rst_then_gnt2", {62'h0, gnt_idx}, 64'd2);
    tick();
    slv_valid = '0; mst_ready = 1'b0;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
